sim_exit_ctrl: RTL
==================

Name: sim_exit_ctrl

Overview:
- Memory-mapped OBI responder inside the system that firmware writes to in order to end a simulation.
- Drives exit_valid_o/exit_value_o, which propagate to the testbench exit monitor.
- Also provides a hardware kernel-interval timer: firmware brackets accelerator kernels (NM-Carus/NM-Caesar) with start/stop writes; the block accumulates cycles and raises timer_trig_o while running. timer_trig_o drives the GPIO-style trigger used for triggered VCD dumps.

Parameters:
DrainCycles, 4, sys_clk cycles between EXIT_VALUE write grant and exit_valid_o assertion (0 allowed; max 255)
AddrWidth, 32, OBI address width

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
addr_i  in  AddrWidth  byte address; only addr_i[4:2] decoded
we_i  in  1  write enable
be_i  in  4  byte enables
wdata_i  in  32  write data
rvalid_o  out  1  OBI response valid
rdata_o  out  32  read data
exit_valid_o  out  1  sticky simulation-exit flag
exit_value_o  out  32  program return value
timer_trig_o  out  1  high while interval timer is running

Behaviour:
- Reset: sys_rst_n asynchronous, active-low; clock sys_clk. All registers, gnt_o, rvalid_o, rdata_o, exit_valid_o, exit_value_o and timer_trig_o reset to 0.
- OBI handshake:
  - gnt_o = req_i (combinational, always grant).
  - rvalid_o pulses exactly 1 cycle after each granted request.
  - rdata_o is valid with rvalid_o: read data for reads, 0 for writes.
  - Back-to-back requests are sustained at 1 per cycle.
  - Register side effects occur on the grant edge.
  - Read data is sampled at the grant cycle, before that cycle's updates.
- Register map (word offset):
  - 0x00 EXIT_VALUE RW, byte-enable honoured.
  - 0x04 TIMER_CTRL WO, be_i[0] must be set. bit0 START, bit1 STOP, bit2 CLEAR. Reads 0.
  - 0x08 TIMER_CYCLES RO, accumulated running cycles.
  - 0x0C TIMER_COUNT RO, completed intervals.
  - 0x10 STATUS RO: bit0 running, bit1 exit_pending, bit2 exited, bit3 ctrl_err.
  - Other offsets: read 0, writes ignored, still granted/responded.
- Exit FSM (IDLE, DRAIN, EXITED):
  - IDLE: EXIT_VALUE write updates exit value and drain counter = DrainCycles. Next state is DRAIN, or EXITED directly if DrainCycles = 0.
  - DRAIN: counter decrements each cycle; at 0 go to EXITED. Further EXIT_VALUE writes are ignored (first value wins).
  - EXITED: exit_valid_o = 1, sticky until reset. exit_value_o frozen; writes ignored.
  - exit_value_o mirrors the stored value in all states.
  - exit_pending = (state == DRAIN).
- Interval timer:
  - START while idle: running = 1 from the next cycle.
  - STOP while running: running = 0; TIMER_COUNT += 1 (wraps at 2^32).
  - START while running and STOP while idle are ignored (no error).
  - TIMER_CYCLES += 1 on every cycle running = 1, saturating at 0xFFFFFFFF. Accumulates across intervals.
  - CLEAR has priority over START and STOP: zero cycles, count and ctrl_err, and set running = 0.
  - START and STOP in the same write (without CLEAR): no state change; set ctrl_err (sticky until CLEAR or reset).
  - timer_trig_o = running (registered).
  - Timer is independent of the exit FSM; it keeps counting after exit.
- Reset mid-operation aborts DRAIN and clears the timer immediately (asynchronous).

Test Plan:
- Reset, DrainCycles=4: write EXIT_VALUE=0 at cycle T -> exit_valid_o rises at T+5 (grant edge + 4 drain), exit_value_o=0, rvalid_o pulses at T+1; STATUS read during drain returns 0x2.
- Write EXIT_VALUE=0xFFFFFFFF then 7 during DRAIN -> exit_value_o=0xFFFFFFFF, exit_valid_o sticky for 100 cycles; be_i=4'b0001 write of 0x12345678 from reset gives 0x00000078.
- START, idle 37 cycles, STOP, then START/STOP again with 10-cycle gap -> TIMER_CYCLES=47, TIMER_COUNT=2, timer_trig_o high exactly during the intervals.
- TIMER_CTRL=0x3 -> STATUS=0x8, no running; then TIMER_CTRL=0x7 -> STATUS=0, cycles/count 0; START+CLEAR -> stays idle.
- Force TIMER_CYCLES near 0xFFFFFFFE and run 5 cycles -> saturates at 0xFFFFFFFF; assert sys_rst_n low mid-DRAIN -> all outputs 0 immediately, no exit afterwards.
- Back-to-back 4 requests (write, read, unmapped read 0x1C, write) -> 4 grants, 4 rvalid_o pulses each 1 cycle later, unmapped rdata_o=0.

Source files
------------

// File: rtl/sim_exit_ctrl.sv
// sim_exit_ctrl: OBI-mapped simulation-exit responder with a kernel-interval
// cycle timer. Firmware writes EXIT_VALUE to end the run (after a drain delay)
// and brackets kernels with TIMER_CTRL start/stop writes.
module sim_exit_ctrl #(
  parameter int unsigned DrainCycles = 4,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 exit_valid_o,
  output logic [31:0]          exit_value_o,
  output logic                 timer_trig_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_EXITED
  } exit_state_t;

  localparam logic [2:0] OFFS_EXIT_VALUE = 3'd0;
  localparam logic [2:0] OFFS_TIMER_CTRL = 3'd1;
  localparam logic [2:0] OFFS_TIMER_CYC  = 3'd2;
  localparam logic [2:0] OFFS_TIMER_CNT  = 3'd3;
  localparam logic [2:0] OFFS_STATUS     = 3'd4;
  localparam logic [7:0] DRAIN_INIT      = 8'(DrainCycles);

  exit_state_t r_state;
  logic [7:0]  r_drain_cnt;
  logic [31:0] r_exit_value;
  logic        r_exit_valid;
  logic        r_tmr_running;
  logic [31:0] r_tmr_cycles;
  logic [31:0] r_tmr_count;
  logic        r_ctrl_err;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic [2:0]  w_offs;
  logic        w_wr_exit;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_stop;
  logic        w_clear;
  logic [31:0] w_exit_merged;
  logic [31:0] w_rdata;
  logic        w_addr_unused;

  assign gnt_o         = req_i;
  assign w_offs        = addr_i[4:2];
  assign w_addr_unused = ^{addr_i[AddrWidth-1:5], addr_i[1:0]};
  assign w_wr_exit     = req_i && we_i && (w_offs == OFFS_EXIT_VALUE);
  assign w_wr_ctrl     = req_i && we_i && (w_offs == OFFS_TIMER_CTRL) && be_i[0];
  assign w_start       = w_wr_ctrl && wdata_i[0];
  assign w_stop        = w_wr_ctrl && wdata_i[1];
  assign w_clear       = w_wr_ctrl && wdata_i[2];

  // Byte-enable merge of write data into the stored exit value.
  always_comb begin
    w_exit_merged = r_exit_value;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_i[i]) w_exit_merged[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  // Read mux; sampled at the grant cycle so it reflects pre-update state.
  always_comb begin
    w_rdata = '0;
    case (w_offs)
      OFFS_EXIT_VALUE: w_rdata = r_exit_value;
      OFFS_TIMER_CYC:  w_rdata = r_tmr_cycles;
      OFFS_TIMER_CNT:  w_rdata = r_tmr_count;
      OFFS_STATUS:     w_rdata = {28'd0, r_ctrl_err, (r_state == ST_EXITED),
                                  (r_state == ST_DRAIN), r_tmr_running};
      default:         w_rdata = '0;
    endcase
  end

  // OBI response: one-cycle rvalid per grant, read data or zero for writes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
    end
  end

  // Exit FSM: first EXIT_VALUE write wins, drains, then latches exit_valid.
  // Leaving DRAIN when the counter is at 1 makes exit_valid rise exactly
  // DrainCycles cycles after the response cycle of the write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_drain_cnt  <= '0;
      r_exit_value <= '0;
      r_exit_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_exit) begin
            r_exit_value <= w_exit_merged;
            r_drain_cnt  <= DRAIN_INIT;
            if (DRAIN_INIT == 8'd0) begin
              r_state      <= ST_EXITED;
              r_exit_valid <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt <= 8'd1) begin
            r_drain_cnt  <= '0;
            r_state      <= ST_EXITED;
            r_exit_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 8'd1;
          end
        end
        ST_EXITED: begin
          r_exit_valid <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Interval timer: CLEAR dominates; START+STOP together flags ctrl_err.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tmr_running <= 1'b0;
      r_tmr_cycles  <= '0;
      r_tmr_count   <= '0;
      r_ctrl_err    <= 1'b0;
    end else if (w_clear) begin
      r_tmr_running <= 1'b0;
      r_tmr_cycles  <= '0;
      r_tmr_count   <= '0;
      r_ctrl_err    <= 1'b0;
    end else begin
      if (r_tmr_running && (r_tmr_cycles != '1)) begin
        r_tmr_cycles <= r_tmr_cycles + 32'd1;
      end
      if (w_start && w_stop) begin
        r_ctrl_err <= 1'b1;
      end else if (w_start && !r_tmr_running) begin
        r_tmr_running <= 1'b1;
      end else if (w_stop && r_tmr_running) begin
        r_tmr_running <= 1'b0;
        r_tmr_count   <= r_tmr_count + 32'd1;
      end
    end
  end

  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign exit_valid_o = r_exit_valid;
  assign exit_value_o = r_exit_value;
  assign timer_trig_o = r_tmr_running;

endmodule
